// File: rtl/taxi_axis_tx_arb.sv
// Frame-level round-robin arbiter sharing one MAC TX AXI-stream among PORTS sources.
// Output is registered (1 cycle latency); one arbitration bubble per frame, then one beat per cycle.

module taxi_axis_tx_arb #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic                      tx_clk,
  input  logic                      tx_rst,
  input  logic [PORTS-1:0]          port_en,
  input  logic [PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [PORTS*USER_W-1:0]   s_axis_tuser,
  input  logic [PORTS-1:0]          s_axis_tlast,
  input  logic [PORTS-1:0]          s_axis_tvalid,
  output logic [PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic [USER_W-1:0]         m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      grant_valid,
  output logic [$clog2(PORTS)-1:0]  grant_idx,
  output logic [CNT_W-1:0]          frame_count
);

  localparam int IDX_W = $clog2(PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  // First requester strictly after the previous owner, wrapping modulo PORTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [PORTS-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    for (int k = PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % PORTS);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_vld_q, grant_vld_d;
  logic               m_vld_q, m_vld_d;
  logic [DATA_W-1:0]  m_dat_q, m_dat_d;
  logic [KEEP_W-1:0]  m_keep_q, m_keep_d;
  logic [USER_W-1:0]  m_user_q, m_user_d;
  logic               m_last_q, m_last_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [PORTS-1:0]   req;
  logic [DATA_W-1:0]  sel_dat;
  logic [KEEP_W-1:0]  sel_keep;
  logic [USER_W-1:0]  sel_user;
  logic               sel_last;
  logic               sel_vld;
  logic               in_rdy;
  logic               in_hs;

  assign req = s_axis_tvalid & port_en;

  always_comb begin
    sel_dat  = '0;
    sel_keep = '0;
    sel_user = '0;
    sel_last = 1'b0;
    sel_vld  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_dat  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_keep = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        sel_user = s_axis_tuser[i*USER_W +: USER_W];
        sel_last = s_axis_tlast[i];
        sel_vld  = s_axis_tvalid[i];
      end
    end
  end

  // Ready only to the owner, and only when the output register is free this cycle.
  assign in_rdy = (state_q == ST_ACTIVE) && (m_axis_tready || !m_vld_q);
  assign in_hs  = in_rdy && sel_vld;

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (in_rdy && grant_idx_q == IDX_W'(i)) s_axis_tready[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_vld_d = grant_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_ACTIVE;
          grant_idx_d = rr_pick(req, grant_idx_q);
          grant_vld_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (in_hs && sel_last) begin
          state_d     = ST_IDLE;
          grant_vld_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_vld_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    m_vld_d  = m_vld_q;
    m_dat_d  = m_dat_q;
    m_keep_d = m_keep_q;
    m_user_d = m_user_q;
    m_last_d = m_last_q;
    if (in_hs) begin
      m_vld_d  = 1'b1;
      m_dat_d  = sel_dat;
      m_keep_d = sel_keep;
      m_user_d = sel_user;
      m_last_d = sel_last;
    end else if (m_axis_tready) begin
      m_vld_d = 1'b0;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (m_vld_q && m_axis_tready && m_last_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= LAST_PORT;
      grant_vld_q <= 1'b0;
      m_vld_q     <= 1'b0;
      m_dat_q     <= '0;
      m_keep_q    <= '0;
      m_user_q    <= '0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
      m_vld_q     <= m_vld_d;
      m_dat_q     <= m_dat_d;
      m_keep_q    <= m_keep_d;
      m_user_q    <= m_user_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign grant_valid   = grant_vld_q;
  assign grant_idx     = grant_idx_q;
  assign frame_count   = frame_cnt_q;

endmodule

// File: doc/taxi_axis_tx_arb.md
Name: taxi_axis_tx_arb

Overview:
- Frame-level round-robin arbiter that shares the single 64-bit MAC TX AXI-stream between PORTS upstream sources (e.g. host DMA, loopback, pause/control generator).
- Once granted, a source owns the stream until its tlast beat is accepted, so frames are never interleaved.
- Sits directly in front of the MAC TX sink.
- Output is registered; throughput is one beat per cycle inside a frame.

Parameters:
- PORTS, 4, number of source ports (2..8)
- DATA_W, 64, tdata width in bits
- KEEP_W, DATA_W/8, tkeep width
- USER_W, 2, tuser width
- CNT_W, 32, width of the forwarded-frame counter

Ports:
- tx_clk  in  1  clock; all logic is on the rising edge
- tx_rst  in  1  synchronous, active-low reset
- port_en  in  PORTS  per-port enable mask; a 0 bit means the port is never newly granted
- s_axis_tdata  in  PORTS*DATA_W  source data, port i at bits [i*DATA_W +: DATA_W]
- s_axis_tkeep  in  PORTS*KEEP_W  source byte enables
- s_axis_tuser  in  PORTS*USER_W  source sideband
- s_axis_tlast  in  PORTS  end-of-frame marker
- s_axis_tvalid  in  PORTS  source valid
- s_axis_tready  out  PORTS  source ready; at most one bit is set per cycle
- m_axis_tdata  out  DATA_W  to MAC TX
- m_axis_tkeep  out  KEEP_W
- m_axis_tuser  out  USER_W
- m_axis_tlast  out  1
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- grant_valid  out  1  high while a frame is owned
- grant_idx  out  $clog2(PORTS)  currently or last granted port
- frame_count  out  CNT_W  number of frames whose tlast beat was accepted on m_axis; wraps

Behaviour:
Reset (tx_rst=0 at a clock edge):
- m_axis_tvalid=0; m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast=0.
- s_axis_tready=0, grant_valid=0, grant_idx=PORTS-1, frame_count=0; state goes to IDLE.
- Reset mid-frame truncates the frame: the output register is discarded and no tlast is emitted.

State machine:
- IDLE:
  - req = s_axis_tvalid & port_en.
  - If req≠0, pick the first set bit searching upward from grant_idx+1 modulo PORTS.
  - Register grant_idx = that port, set grant_valid=1, go to ACTIVE.
  - s_axis_tready=0 in IDLE, so there is a 1-cycle arbitration bubble per frame.
- ACTIVE:
  - s_axis_tready[grant_idx] = m_axis_tready | ~m_axis_tvalid; all other ready bits are 0.
  - On an input handshake (valid & ready on the granted port), the beat is loaded into the output register and m_axis_tvalid=1 on the next cycle (latency 1).
  - If the output register holds a beat and m_axis_tready=1 with no new input beat, m_axis_tvalid drops to 0.
  - When the input handshake has s_axis_tlast=1: the next state is IDLE, grant_valid=0, and grant_idx is kept as the round-robin pointer.
- The output register may still hold the tlast beat while the arbiter is in IDLE. The next grant may be made in that state, but no new input beat is accepted until the register is free, per the ready rule above.

AXI-stream rules:
- m_axis_* are stable while m_axis_tvalid=1 and m_axis_tready=0.
- tkeep and tuser pass through unmodified; no byte reordering.

Boundary conditions:
- port_en changes mid-frame do not affect the current owner; they only affect the next arbitration.
- Granted source drops tvalid mid-frame: the grant is held with no timeout and the output goes idle (m_axis_tvalid=0 after drain).
- Single-beat frame (tlast on the first beat) is legal: ACTIVE lasts 1 cycle.
- frame_count increments on an m_axis handshake with m_axis_tlast=1 and wraps from 2^CNT_W−1 to 0.
- All requesters idle: stay in IDLE, outputs idle.

Test Plan:
1. Reset, then port0 sends a 3-beat frame with tkeep ff, ff, 0f and m_axis_tready=1 -> first m_axis beat 2 cycles after tvalid (arb + register), beats identical, tlast on beat 3, frame_count=1.
2. All 4 ports hold 1-beat frames continuously -> grant order 0, 1, 2, 3, 0, … and each port gets exactly 1 frame per 4 frames.
3. Port1 streams a 5-beat frame while port0 asserts valid mid-frame -> no interleave; port0 is granted only after port1's tlast; s_axis_tready is never one-hot-violated.
4. m_axis_tready toggles 1,0,0,1 during a frame -> no beat lost or duplicated; m_axis_* held stable while stalled.
5. port_en=4'b1101 with ports 1 and 2 requesting -> only port 2 is served; clearing port_en[2] mid-frame still completes that frame.
6. tx_rst=0 asserted on beat 2 of a 4-beat frame -> next cycle m_axis_tvalid=0, frame_count=0, grant_valid=0; after release, port0 is arbitrated first.
